// File: rtl/enc_rd_ctrl.sv
// enc_rd_ctrl: 8b/10b running-disparity controller and 10-bit symbol assembler with K28.5 insertion
module enc_rd_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vld_in,
  input  logic       k_in,
  input  logic [4:0] d_5b,
  input  logic [5:0] d_6b,
  input  logic       alt_6b,
  input  logic [3:0] d_4b,
  output logic [9:0] sym_10b,
  output logic       vld_out,
  output logic       rd_out,
  output logic       code_err
);
  logic [2:0] p6, p4, p4_raw;
  logic       cmp6, rd_mid, a7, cmp4, rd_next, bad;
  logic [5:0] s6;
  logic [3:0] n4, s4;
  logic [9:0] k_sym;
  always_comb begin
    p6      = 3'($countones(d_6b));
    p4_raw  = 3'($countones(d_4b));
    cmp6    = rd_out & (alt_6b | (p6 != 3'd3) | (d_6b == 6'b111000));
    s6      = cmp6 ? ~d_6b : d_6b;
    rd_mid  = rd_out ^ (p6 != 3'd3);
    a7      = (d_4b == 4'b1110) && (rd_mid ? (d_5b == 5'd11 || d_5b == 5'd13 || d_5b == 5'd14)
                                           : (d_5b == 5'd17 || d_5b == 5'd18 || d_5b == 5'd20));
    n4      = a7 ? 4'b0111 : d_4b;
    p4      = 3'($countones(n4));
    cmp4    = rd_mid & ((p4 != 3'd2) | (n4 == 4'b1100));
    s4      = cmp4 ? ~n4 : n4;
    rd_next = rd_mid ^ (p4 != 3'd2);
    bad     = (p6 != 3'd3 && p6 != 3'd4) || (p4_raw != 3'd2 && p4_raw != 3'd3);
    k_sym   = rd_out ? 10'b1100000101 : 10'b0011111010;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_10b  <= '0;
      vld_out  <= 1'b0;
      rd_out   <= 1'b0;
      code_err <= 1'b0;
    end else begin
      vld_out  <= vld_in;
      code_err <= vld_in & ~k_in & bad;
      if (vld_in) begin
        sym_10b <= k_in ? k_sym : {s6, s4};
        rd_out  <= k_in ? ~rd_out : rd_next;
      end
    end
  end
endmodule
